// File: rtl/regmap_pkg.sv
// Shared types and constants for the register-map NVM shadow loader.
package regmap_pkg;

   localparam int REG_AW = 8;
   localparam int REG_DW = 8;
   localparam int IDX_W  = 4;

   typedef enum logic [2:0] {IDLE, WAIT_NB, READ, WAIT_DATA, WRITE, DONE} ldr_state_t;

   localparam logic [REG_AW-1:0] SHADOW_BASE_DEF  = 8'hE0;
   localparam int                SHADOW_WORDS_DEF = 2;

   // Offset is taken modulo 256 so the window follows the same wrap as loader addresses.
   function automatic logic in_shadow(input logic [REG_AW-1:0] addr,
                                      input logic [REG_AW-1:0] base,
                                      input int                words);
      logic [REG_AW-1:0] off;
      off = addr - base;
      return (int'(off) < words);
   endfunction

endpackage

// File: rtl/regmap_wr_arb.sv
// Registered write-port mux: loader first, host otherwise, host stalled on the shadow window during a load.
module regmap_wr_arb
   import regmap_pkg::*;
#(
   parameter logic [REG_AW-1:0] NVM_BASE  = SHADOW_BASE_DEF,
   parameter int                NVM_WORDS = SHADOW_WORDS_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enable,
   input  logic              i_ldr_wr,
   input  logic [REG_AW-1:0] i_ldr_addr,
   input  logic [REG_DW-1:0] i_ldr_wdat,
   input  logic              i_host_wr,
   input  logic [REG_AW-1:0] i_host_addr,
   input  logic [REG_DW-1:0] i_host_wdat,
   input  logic [REG_DW-1:0] i_host_mask,
   input  logic              i_load_busy,
   output logic              o_host_ack,
   output logic              o_reg_wr,
   output logic [REG_AW-1:0] o_reg_addr,
   output logic [REG_DW-1:0] o_reg_wdat,
   output logic [REG_DW-1:0] o_reg_mask
);

   logic              w_stall, w_ldr_gnt, w_host_gnt;
   logic              r_wr;
   logic [REG_AW-1:0] r_addr;
   logic [REG_DW-1:0] r_wdat, r_mask;

   assign w_stall    = i_load_busy && in_shadow(i_host_addr, NVM_BASE, NVM_WORDS);
   assign w_ldr_gnt  = i_enable && !rst && i_ldr_wr;
   assign w_host_gnt = i_enable && !rst && i_host_wr && !i_ldr_wr && !w_stall;
   assign o_host_ack = w_host_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr   <= 1'b0;
         r_addr <= '0;
         r_wdat <= '0;
         r_mask <= '0;
      end else if (i_enable) begin
         if (w_ldr_gnt) begin
            r_wr   <= 1'b1;
            r_addr <= i_ldr_addr;
            r_wdat <= i_ldr_wdat;
            r_mask <= '0;
         end else if (w_host_gnt) begin
            r_wr   <= 1'b1;
            r_addr <= i_host_addr;
            r_wdat <= i_host_wdat;
            r_mask <= i_host_mask;
         end else begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_wdat <= '0;
            r_mask <= '0;
         end
      end
   end

   // A strobe registered just before enable drops is delivered once enable returns.
   assign o_reg_wr   = r_wr && i_enable;
   assign o_reg_addr = r_addr;
   assign o_reg_wdat = r_wdat;
   assign o_reg_mask = r_mask;

endmodule

// File: rtl/regmap_nvm_loader.sv
// NVM-to-regmap shadow loader FSM; shares the regmap write port with the host through regmap_wr_arb.
module regmap_nvm_loader
   import regmap_pkg::*;
#(
   parameter logic [REG_AW-1:0] NVM_BASE  = 8'hE0,
   parameter int                NVM_WORDS = 2,
   parameter int                NVM_AW    = 4,
   parameter int                TIMEOUT   = 255,
   parameter bit                AUTO_LOAD = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              load_req,
   input  logic              host_wr,
   input  logic [REG_AW-1:0] host_wr_addr,
   input  logic [REG_DW-1:0] host_wdat,
   input  logic [REG_DW-1:0] host_mask,
   output logic              host_wr_ack,
   input  logic              nvm_busy,
   output logic              nvm_rd_en,
   output logic [NVM_AW-1:0] nvm_rd_addr,
   input  logic [REG_DW-1:0] nvm_rd_data,
   input  logic              nvm_rd_valid,
   output logic              reg_wr,
   output logic [REG_AW-1:0] reg_wr_addr,
   output logic [REG_DW-1:0] reg_wdat,
   output logic [REG_DW-1:0] reg_mask,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NVM_WORDS - 1);
   localparam logic [7:0]       TO_LIM   = 8'(TIMEOUT);

   ldr_state_t        r_state, w_next;
   logic [IDX_W-1:0]  r_idx;
   logic [7:0]        r_cnt;
   logic [REG_DW-1:0] r_data;
   logic              r_err, r_auto;
   logic              w_last, w_timeout;

   assign w_last    = (r_idx == IDX_LAST);
   assign w_timeout = (r_cnt == TO_LIM);

   always_ff @(posedge clk) begin
      if (rst)         r_state <= IDLE;
      else if (enable) r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (load_req || r_auto) w_next = WAIT_NB;
         WAIT_NB:   if (!nvm_busy) w_next = READ;
         READ:      w_next = WAIT_DATA;
         WAIT_DATA: begin
            if (nvm_rd_valid)   w_next = WRITE;
            else if (w_timeout) w_next = w_last ? DONE : WAIT_NB;
         end
         WRITE:     w_next = w_last ? DONE : WAIT_NB;
         DONE:      w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // r_auto arms the post-reset load; it is consumed on the first enabled IDLE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
         r_err  <= 1'b0;
         r_auto <= AUTO_LOAD;
      end else if (enable) begin
         case (r_state)
            IDLE: if (w_next == WAIT_NB) begin
               r_idx  <= '0;
               r_err  <= 1'b0;
               r_auto <= 1'b0;
            end
            READ: r_cnt <= '0;
            WAIT_DATA: begin
               if (nvm_rd_valid) begin
                  r_data <= nvm_rd_data;
               end else if (w_timeout) begin
                  r_err <= 1'b1;
                  if (!w_last) r_idx <= r_idx + 1'b1;
               end else if (r_cnt != 8'hFF) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WRITE: if (!w_last) r_idx <= r_idx + 1'b1;
            default: ;
         endcase
      end
   end

   assign nvm_rd_en   = enable && (r_state == READ);
   assign nvm_rd_addr = NVM_AW'(r_idx);
   assign load_busy   = (r_state != IDLE);
   assign load_done   = enable && (r_state == DONE);
   assign load_err    = r_err;

   regmap_wr_arb #(
      .NVM_BASE  (NVM_BASE),
      .NVM_WORDS (NVM_WORDS)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_enable    (enable),
      .i_ldr_wr    (r_state == WRITE),
      .i_ldr_addr  (NVM_BASE + {4'd0, r_idx}),
      .i_ldr_wdat  (r_data),
      .i_host_wr   (host_wr),
      .i_host_addr (host_wr_addr),
      .i_host_wdat (host_wdat),
      .i_host_mask (host_mask),
      .i_load_busy (load_busy),
      .o_host_ack  (host_wr_ack),
      .o_reg_wr    (reg_wr),
      .o_reg_addr  (reg_wr_addr),
      .o_reg_wdat  (reg_wdat),
      .o_reg_mask  (reg_mask)
   );

endmodule

// File: tb/tb_regmap_nvm_loader.sv
// Directed scoreboard bench for regmap_nvm_loader with a 1-cycle-latency NVM model.
module tb_regmap_nvm_loader;

   logic       clk = 1'b0;
   logic       rst, enable, load_req, host_wr, nvm_busy, nvm_rd_valid;
   logic [7:0] host_wr_addr, host_wdat, host_mask, nvm_rd_data;
   logic       host_wr_ack, nvm_rd_en, reg_wr, load_busy, load_done, load_err;
   logic [3:0] nvm_rd_addr;
   logic [7:0] reg_wr_addr, reg_wdat, reg_mask;

   typedef struct packed {logic [7:0] a; logic [7:0] d; logic [7:0] m;} wr_t;
   wr_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   logic [7:0] nvm_mem [16];
   logic       drop_en = 1'b0;
   logic [3:0] drop_addr = 4'd0;
   logic       pend = 1'b0;
   logic [3:0] paddr = 4'd0;

   always #5 clk = ~clk;

   regmap_nvm_loader dut (
      .clk(clk), .rst(rst), .enable(enable), .load_req(load_req),
      .host_wr(host_wr), .host_wr_addr(host_wr_addr), .host_wdat(host_wdat),
      .host_mask(host_mask), .host_wr_ack(host_wr_ack), .nvm_busy(nvm_busy),
      .nvm_rd_en(nvm_rd_en), .nvm_rd_addr(nvm_rd_addr), .nvm_rd_data(nvm_rd_data),
      .nvm_rd_valid(nvm_rd_valid), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
      .reg_wdat(reg_wdat), .reg_mask(reg_mask), .load_busy(load_busy),
      .load_done(load_done), .load_err(load_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] d, input logic [7:0] m);
      exp_q.push_back({a, d, m});
   endtask

   task automatic wait_done(input int bound, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (load_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
         step();
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   // NVM model: a read strobe seen in cycle k yields valid data in cycle k+1.
   always @(negedge clk) begin
      pend  = nvm_rd_en;
      paddr = nvm_rd_addr;
   end

   always @(posedge clk) begin
      #1;
      nvm_rd_valid = pend && !(drop_en && paddr == drop_addr);
      nvm_rd_data  = nvm_mem[paddr];
      pend = 1'b0;
   end

   // Scoreboard: each observed write must match some pending expected write.
   always @(negedge clk) begin
      if (load_done === 1'b1) done_cnt++;
      if (reg_wr === 1'b1) begin
         int hit;
         hit = -1;
         foreach (exp_q[i]) if (hit < 0 && exp_q[i] == {reg_wr_addr, reg_wdat, reg_mask}) hit = i;
         if (hit >= 0) exp_q.delete(hit);
         chk($sformatf("wr_a%02h_d%02h_m%02h", reg_wr_addr, reg_wdat, reg_mask),
             32'(hit >= 0), 32'd1);
      end
   end

   initial begin
      bit acked, busy_at_ack, rd_seen;
      foreach (nvm_mem[i]) nvm_mem[i] = 8'(i * 16 + 1);
      nvm_mem[0] = 8'h5A;
      nvm_mem[1] = 8'hC3;
      rst = 1'b1; enable = 1'b1; load_req = 1'b0; host_wr = 1'b0;
      host_wr_addr = 8'h00; host_wdat = 8'h00; host_mask = 8'h00;
      nvm_busy = 1'b0; nvm_rd_valid = 1'b0; nvm_rd_data = 8'h00;

      // reset state
      step(); step();
      @(negedge clk);
      chk("rst_reg_wr", 32'(reg_wr), 0);
      chk("rst_reg_addr", 32'(reg_wr_addr), 0);
      chk("rst_busy", 32'(load_busy), 0);
      chk("rst_done", 32'(load_done), 0);
      chk("rst_err", 32'(load_err), 0);
      chk("rst_rd_en", 32'(nvm_rd_en), 0);

      // auto load after reset release
      push(8'hE0, 8'h5A, 8'h00);
      push(8'hE1, 8'hC3, 8'h00);
      step(); rst = 1'b0;
      wait_done(100, "auto_done");
      chk("auto_err", 32'(load_err), 0);
      step();
      @(negedge clk);
      chk("auto_idle", 32'(load_busy), 0);
      chk("auto_done_cnt", 32'(done_cnt), 1);
      step();
      chk("auto_q_empty", 32'(exp_q.size()), 0);

      // host write collides with the loader WRITE cycle
      push(8'hE0, 8'h5A, 8'h00);
      push(8'hE1, 8'hC3, 8'h00);
      load_req = 1'b1;                       // cycle c
      step(); load_req = 1'b0;               // c+1
      step(); step(); step();                // c+4: WRITE
      host_wr = 1'b1; host_wr_addr = 8'h48; host_wdat = 8'h15; host_mask = 8'h00;
      push(8'h48, 8'h15, 8'h00);
      @(negedge clk);
      chk("coll_ack_held", 32'(host_wr_ack), 0);
      step();                                // c+5
      @(negedge clk);
      chk("coll_ack_next", 32'(host_wr_ack), 1);
      chk("coll_ldr_first", 32'(reg_wr_addr), 32'hE0);
      step(); host_wr = 1'b0;                // c+6
      @(negedge clk);
      chk("coll_host_wr", 32'(reg_wr), 1);
      chk("coll_host_addr", 32'(reg_wr_addr), 32'h48);
      wait_done(50, "coll_done");
      step(); step();
      chk("coll_q_empty", 32'(exp_q.size()), 0);

      // host write to a shadowed address stalls until the load ends
      push(8'hE0, 8'h5A, 8'h00);
      push(8'hE1, 8'hC3, 8'h00);
      load_req = 1'b1;
      step(); load_req = 1'b0;
      host_wr = 1'b1; host_wr_addr = 8'hE1; host_wdat = 8'h77; host_mask = 8'hF0;
      push(8'hE1, 8'h77, 8'hF0);
      acked = 1'b0; busy_at_ack = 1'b1;
      @(negedge clk);
      chk("stall_first", 32'(host_wr_ack), 0);
      step();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (host_wr_ack === 1'b1) begin
            acked = 1'b1;
            busy_at_ack = load_busy;
            break;
         end
         step();
      end
      chk("stall_acked", 32'(acked), 1);
      chk("stall_busy_at_ack", 32'(busy_at_ack), 0);
      step(); host_wr = 1'b0;
      step(); step();
      chk("stall_q_empty", 32'(exp_q.size()), 0);

      // host write outside the shadow window is acked during a load
      push(8'hE0, 8'h5A, 8'h00);
      push(8'hE1, 8'hC3, 8'h00);
      load_req = 1'b1;
      step(); load_req = 1'b0;
      step();
      host_wr = 1'b1; host_wr_addr = 8'h49; host_wdat = 8'hA5; host_mask = 8'h0F;
      push(8'h49, 8'hA5, 8'h0F);
      @(negedge clk);
      chk("nostall_busy", 32'(load_busy), 1);
      chk("nostall_ack", 32'(host_wr_ack), 1);
      step(); host_wr = 1'b0;
      wait_done(50, "nostall_done");
      step(); step();
      chk("nostall_q_empty", 32'(exp_q.size()), 0);

      // word 0 times out: skipped, error flagged, word 1 still written
      drop_en = 1'b1; drop_addr = 4'd0;
      push(8'hE1, 8'hC3, 8'h00);
      load_req = 1'b1;
      step(); load_req = 1'b0;
      wait_done(600, "to_done");
      chk("to_err", 32'(load_err), 1);
      step(); step();
      chk("to_q_empty", 32'(exp_q.size()), 0);
      drop_en = 1'b0;
      push(8'hE0, 8'h5A, 8'h00);
      push(8'hE1, 8'hC3, 8'h00);
      load_req = 1'b1;
      step(); load_req = 1'b0;
      @(negedge clk);
      chk("to_err_cleared", 32'(load_err), 0);
      wait_done(50, "to_reload_done");
      step(); step();

      // nvm_busy holds off the first read
      push(8'hE0, 8'h5A, 8'h00);
      push(8'hE1, 8'hC3, 8'h00);
      nvm_busy = 1'b1; load_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step(); load_req = 1'b0;
         @(negedge clk);
         chk("busy_no_rd", 32'(nvm_rd_en), 0);
      end
      step(); nvm_busy = 1'b0;
      @(negedge clk);
      chk("busy_fall_rd", 32'(nvm_rd_en), 0);
      step();
      @(negedge clk);
      chk("busy_rd_en", 32'(nvm_rd_en), 1);
      chk("busy_rd_addr", 32'(nvm_rd_addr), 0);
      wait_done(50, "busy_done");
      step(); step();
      chk("busy_q_empty", 32'(exp_q.size()), 0);

      // reset during WAIT_DATA of word 1 aborts; auto load restarts at index 0
      drop_en = 1'b1; drop_addr = 4'd1;
      push(8'hE0, 8'h5A, 8'h00);
      load_req = 1'b1;
      step(); load_req = 1'b0;
      for (int i = 0; i < 8; i++) step();    // c+9: WAIT_DATA of word 1
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("abort_reg_wr", 32'(reg_wr), 0);
      chk("abort_reg_data", 32'({reg_wr_addr, reg_wdat, reg_mask}), 0);
      chk("abort_busy", 32'(load_busy), 0);
      chk("abort_rd", 32'({nvm_rd_en, nvm_rd_addr}), 0);
      chk("abort_flags", 32'({load_done, load_err}), 0);
      chk("abort_q_empty", 32'(exp_q.size()), 0);
      step();
      rst = 1'b0; drop_en = 1'b0;
      push(8'hE0, 8'h5A, 8'h00);
      push(8'hE1, 8'hC3, 8'h00);
      rd_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (nvm_rd_en === 1'b1) begin
            rd_seen = 1'b1;
            break;
         end
         step();
      end
      chk("reload_rd_seen", 32'(rd_seen), 1);
      chk("reload_idx0", 32'(nvm_rd_addr), 0);
      step();
      wait_done(50, "reload_done");
      step(); step();
      chk("reload_q_empty", 32'(exp_q.size()), 0);

      // enable low blocks host grants
      enable = 1'b0;
      host_wr = 1'b1; host_wr_addr = 8'h50; host_wdat = 8'h3C; host_mask = 8'hAA;
      @(negedge clk);
      chk("dis_ack", 32'(host_wr_ack), 0);
      chk("dis_reg_wr", 32'(reg_wr), 0);
      step(); enable = 1'b1;
      push(8'h50, 8'h3C, 8'hAA);
      @(negedge clk);
      chk("en_ack", 32'(host_wr_ack), 1);
      step(); host_wr = 1'b0;
      step();
      chk("en_q_empty", 32'(exp_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
